ring_token_arbiter: RTL and testbench

//   Round-robin arbiter for N requesters sharing one resource. A one-hot

---
 rtl/ring_token_arbiter_if.sv | 35 +++
 rtl/ring_token_arbiter.sv | 143 ++++++++++++++
 tb/tb_ring_token_arbiter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/ring_token_arbiter_if.sv
// rtl/ring_token_arbiter_if.sv - request/grant bundle between requesters and the ring token arbiter
//
// Purpose: groups the arbiter's request and status signals so one port carries them all.
// Signals:
//   req    N  level request vector, one bit per requester (driven by requesters)
//   grant  N  registered one-hot grant, zero when idle (driven by arbiter)
//   token  N  registered one-hot search-start pointer (driven by arbiter)
//   busy   1  high while a grant is held (driven by arbiter)
//   expire 1  one-cycle pulse after a tenure ended by the hold limit (driven by arbiter)
// Modports: master = requester side, slave = arbiter side.
interface ring_token_arbiter_if #(
  parameter int N = 4
) ();
  logic [N-1:0] req;
  logic [N-1:0] grant;
  logic [N-1:0] token;
  logic         busy;
  logic         expire;

  modport master (
    output req,
    input  grant,
    input  token,
    input  busy,
    input  expire
  );

  modport slave (
    input  req,
    output grant,
    output token,
    output busy,
    output expire
  );
endinterface

// File: rtl/ring_token_arbiter.sv
// rtl/ring_token_arbiter.sv - round-robin arbiter with circulating one-hot token and hold limit
//
// Purpose: grants one of N requesters at a time. A one-hot token sets where the
//   priority search starts; a grant is held while its request stays high, up to
//   MAX_HOLD cycles (0 = unlimited), after which the grant rotates to the next
//   requester in ring order.
// Ports:
//   clk  in  clock, all state changes on the rising edge
//   ori  in  asynchronous active-low reset
//   bus  slave modport of ring_token_arbiter_if (req in; grant, token, busy, expire out)
module ring_token_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                 clk,
  input  logic                 ori,
  ring_token_arbiter_if.slave  bus
);

  localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'((MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0);
  localparam logic [HW-1:0] HOLD_SAT  = {HW{1'b1}};

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t        r_state;
  logic [N-1:0]  r_grant;
  logic [N-1:0]  r_token;
  logic [HW-1:0] r_hold;
  logic          r_busy;
  logic          r_expire;

  int            w_tok_idx;
  int            w_nxt_start;
  logic [N-1:0]  w_idle_pick;
  logic [N-1:0]  w_next_pick;
  logic [N-1:0]  w_tok_rotl;
  logic          w_own_req;

  // First set bit of vec scanning upward from index start, wrapping at N.
  function automatic logic [N-1:0] search(input logic [N-1:0] vec, input int start);
    logic [N-1:0] pick;
    int           idx;
    logic         found;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = start + k;
      if (idx >= N) idx = idx - N;
      if (!found && vec[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic int onehot_idx(input logic [N-1:0] v);
    int r;
    r = 0;
    for (int i = 0; i < N; i++) begin
      if (v[i]) r = i;
    end
    return r;
  endfunction

  // In GRANT the token equals the grant, so the token index doubles as the
  // owner index and both search starts derive from it.
  always_comb begin
    w_tok_idx   = onehot_idx(r_token);
    w_nxt_start = (w_tok_idx + 1 >= N) ? 0 : w_tok_idx + 1;
    w_idle_pick = search(bus.req, w_tok_idx);
    // Masking the owner makes a timeout skip it; on release its bit is already low.
    w_next_pick = search(bus.req & ~r_grant, w_nxt_start);
    w_own_req   = |(bus.req & r_grant);
    w_tok_rotl  = '0;
    for (int i = 0; i < N; i++) begin
      w_tok_rotl[(i + 1) % N] = r_token[i];
    end
  end

  always_ff @(posedge clk or negedge ori) begin
    if (!ori) begin
      r_state  <= S_IDLE;
      r_grant  <= '0;
      r_token  <= N'(1);
      r_hold   <= '0;
      r_busy   <= 1'b0;
      r_expire <= 1'b0;
    end else begin
      r_expire <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (|bus.req) begin
            r_grant <= w_idle_pick;
            r_token <= w_idle_pick;
            r_hold  <= '0;
            r_busy  <= 1'b1;
            r_state <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (w_own_req) begin
            if (MAX_HOLD == 0) begin
              if (r_hold != HOLD_SAT) r_hold <= r_hold + 1'b1;
            end else if (r_hold < HOLD_LAST) begin
              r_hold <= r_hold + 1'b1;
            end else begin
              // Timeout: hand over if anyone else waits, otherwise re-grant the owner.
              r_hold   <= '0;
              r_expire <= 1'b1;
              if (|w_next_pick) begin
                r_grant <= w_next_pick;
                r_token <= w_next_pick;
              end
            end
          end else begin
            r_hold <= '0;
            if (|w_next_pick) begin
              r_grant <= w_next_pick;
              r_token <= w_next_pick;
            end else begin
              r_grant <= '0;
              r_token <= w_tok_rotl;
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.grant  = r_grant;
  assign bus.token  = r_token;
  assign bus.busy   = r_busy;
  assign bus.expire = r_expire;

endmodule

// File: tb/tb_ring_token_arbiter.sv
// tb/tb_ring_token_arbiter.sv - directed table-driven bench for ring_token_arbiter
module tb_ring_token_arbiter;

  typedef struct packed {
    logic [3:0] req;
    logic [3:0] grant;
    logic [3:0] token;
    logic       busy;
    logic       expire;
  } vec_t;

  logic clk;
  logic ori;
  int   n_cmp;
  int   n_err;
  vec_t tbl[$];

  ring_token_arbiter_if #(.N(4)) if_a ();
  ring_token_arbiter_if #(.N(4)) if_b ();

  ring_token_arbiter #(.N(4), .MAX_HOLD(4)) dut_a (
    .clk (clk),
    .ori (ori),
    .bus (if_a)
  );

  ring_token_arbiter #(.N(4), .MAX_HOLD(0)) dut_b (
    .clk (clk),
    .ori (ori),
    .bus (if_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %b expected %b", name, idx, act, exp);
    end
  endtask

  task automatic add(input int cnt, input logic [3:0] r, input logic [3:0] g,
                     input logic [3:0] t, input logic b, input logic e);
    vec_t v;
    v.req = r; v.grant = g; v.token = t; v.busy = b; v.expire = e;
    for (int i = 0; i < cnt; i++) tbl.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    ori = 1'b0;
    if_a.req = 4'b0000;
    if_b.req = 4'b0000;

    // Single request after reset, then release to idle (token moves past owner)
    add(1, 4'b0100, 4'b0100, 4'b0100, 1'b1, 1'b0);
    add(1, 4'b0000, 4'b0000, 4'b1000, 1'b0, 1'b0);
    // All requesting: 4-cycle tenures around the ring, expire on each handover
    add(4, 4'b1111, 4'b1000, 4'b1000, 1'b1, 1'b0);
    add(1, 4'b1111, 4'b0001, 4'b0001, 1'b1, 1'b1);
    add(3, 4'b1111, 4'b0001, 4'b0001, 1'b1, 1'b0);
    add(1, 4'b1111, 4'b0010, 4'b0010, 1'b1, 1'b1);
    add(3, 4'b1111, 4'b0010, 4'b0010, 1'b1, 1'b0);
    add(1, 4'b1111, 4'b0100, 4'b0100, 1'b1, 1'b1);
    add(3, 4'b1111, 4'b0100, 4'b0100, 1'b1, 1'b0);
    add(1, 4'b1111, 4'b1000, 4'b1000, 1'b1, 1'b1);
    // Lone requester 0010: released handover, then re-grant with expire every 4
    add(4, 4'b0010, 4'b0010, 4'b0010, 1'b1, 1'b0);
    add(1, 4'b0010, 4'b0010, 4'b0010, 1'b1, 1'b1);
    add(3, 4'b0010, 4'b0010, 4'b0010, 1'b1, 1'b0);
    add(1, 4'b0010, 4'b0010, 4'b0010, 1'b1, 1'b1);
    add(3, 4'b0010, 4'b0010, 4'b0010, 1'b1, 1'b0);
    add(1, 4'b0010, 4'b0010, 4'b0010, 1'b1, 1'b1);
    // Owner 0001 drops while 1010 waits: gapless handover to 0010, then all drop
    add(1, 4'b0001, 4'b0001, 4'b0001, 1'b1, 1'b0);
    add(1, 4'b1010, 4'b0010, 4'b0010, 1'b1, 1'b0);
    add(1, 4'b0000, 4'b0000, 4'b0100, 1'b0, 1'b0);

    // Reset state
    step();
    step();
    chk("rst_grant", 0, if_a.grant, 4'b0000);
    chk("rst_token", 0, if_a.token, 4'b0001);
    chk("rst_busy", 0, {3'b000, if_a.busy}, 4'b0000);
    chk("rst_expire", 0, {3'b000, if_a.expire}, 4'b0000);
    ori = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      if_a.req = tbl[i].req;
      step();
      chk("grant", i, if_a.grant, tbl[i].grant);
      chk("token", i, if_a.token, tbl[i].token);
      chk("busy", i, {3'b000, if_a.busy}, {3'b000, tbl[i].busy});
      chk("expire", i, {3'b000, if_a.expire}, {3'b000, tbl[i].expire});
    end

    // Asynchronous reset mid-tenure
    if_a.req = 4'b1000;
    step();
    chk("pre_rst_grant", 0, if_a.grant, 4'b1000);
    #2;
    ori = 1'b0;
    #1;
    chk("async_rst_grant", 0, if_a.grant, 4'b0000);
    chk("async_rst_token", 0, if_a.token, 4'b0001);
    chk("async_rst_busy", 0, {3'b000, if_a.busy}, 4'b0000);
    if_a.req = 4'b0110;
    step();
    chk("rst_held_grant", 0, if_a.grant, 4'b0000);
    ori = 1'b1;
    step();
    chk("post_rst_grant", 0, if_a.grant, 4'b0010);
    chk("post_rst_token", 0, if_a.token, 4'b0010);
    if_a.req = 4'b0000;

    // Unlimited hold: owner 0001 keeps the grant indefinitely
    if_b.req = 4'b0011;
    step();
    chk("nohold_first", 0, if_b.grant, 4'b0001);
    for (int i = 0; i < 50; i++) begin
      step();
      chk("nohold_grant", i, if_b.grant, 4'b0001);
      chk("nohold_expire", i, {3'b000, if_b.expire}, 4'b0000);
    end
    chk("nohold_busy", 0, {3'b000, if_b.busy}, 4'b0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
